// File: rtl/log_sched_if.sv
// Request/response bundle between NREQ requesters, the scheduler and the
// result consumer.
//
// Handshake: a transfer on any channel happens in exactly the cycle where
// both valid and ready are high at the rising edge of CLK. A source holds
// valid and its payload stable until the transfer. req_ready may depend
// combinationally on req_valid. rsp_valid never depends on rsp_ready.
interface log_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               rsp_err;
   logic               busy;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
   );
endinterface

// File: rtl/log_sched.sv
// log: pipelined natural-log core. Input is d = x - 1.0 in signed fixed
// point; output is the second-order series ln(1+d) ~= d - d*d/2, which is
// accurate near x = 1.0. Latency is N_STAGE+1 cycles and it cannot stall.
//
// log_sched: round-robin scheduler sharing one log core among NREQ
// requesters. Operands are converted to x - 1.0 at issue, tracked through
// the core latency with tag shift registers, and collected in a result FIFO
// that releases results in issue order. Issue is gated by credits so the
// FIFO can absorb everything still in flight when the consumer stalls.
module log #(
   parameter int N_STAGE      = 2,
   parameter int DECIMAL_BITS = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic signed [31:0] data,
   output logic signed [31:0] output_data
);
   logic signed [31:0] d_q;
   logic signed [63:0] d_ext;
   logic signed [63:0] sq;
   logic signed [31:0] approx;
   logic signed [31:0] pipe [N_STAGE];

   // Series term: d - (d*d >> (DECIMAL_BITS+1)), wrapped to 32 bits.
   always_comb begin
      d_ext  = {{32{d_q[31]}}, d_q};
      sq     = d_ext * d_ext;
      approx = d_q - 32'(sq >>> (DECIMAL_BITS + 1));
   end

   // Input register followed by N_STAGE result registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         d_q <= '0;
         for (int i = 0; i < N_STAGE; i++) pipe[i] <= '0;
      end else begin
         d_q     <= data;
         pipe[0] <= approx;
         for (int i = 1; i < N_STAGE; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign output_data = pipe[N_STAGE-1];
endmodule

module log_sched #(
   parameter int NREQ         = 4,
   parameter int IDW          = 2,
   parameter int N_STAGE      = 2,
   parameter int DECIMAL_BITS = 10,
   parameter int FIFO_DEPTH   = 8
) (
   input logic       CLK,
   input logic       RST,
   log_sched_if.slave bus
);
   localparam int          LAT = N_STAGE + 1;
   localparam int          AW  = $clog2(FIFO_DEPTH);
   localparam int          CW  = AW + 1;
   localparam logic [31:0] ONE = 32'(1) << DECIMAL_BITS;

   logic [31:0]        req_x [NREQ];
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     cand;
   logic               grant_any;
   logic [IDW-1:0]     grant_idx;
   logic               credit_ok;
   logic               issue;
   logic [31:0]        sel_data;
   logic               sel_err;
   logic signed [31:0] log_in;
   logic signed [31:0] log_out;

   logic [LAT-1:0]     sr_valid;
   logic [LAT-1:0]     sr_err;
   logic [IDW-1:0]     sr_id [LAT];

   logic [31:0]        fifo_data [FIFO_DEPTH];
   logic [IDW-1:0]     fifo_id   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_err;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      fifo_count;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_x[g] = bus.req_data[g*32 +: 32];
   end

   // Round-robin search starting at rr_ptr; first valid requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDW'((int'(rr_ptr) + i) % NREQ);
         if (!grant_any && bus.req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Credit check, grant and operand preparation for the log core.
   always_comb begin
      credit_ok     = (int'($countones(sr_valid)) + int'(fifo_count)) < FIFO_DEPTH;
      issue         = grant_any && credit_ok && !RST;
      bus.req_ready = '0;
      if (issue) bus.req_ready[grant_idx] = 1'b1;
      sel_data      = req_x[grant_idx];
      sel_err       = $signed(sel_data) <= 32'sd0;
      log_in        = issue ? $signed(sel_data - ONE) : 32'sd0;
   end

   log #(
      .N_STAGE      (N_STAGE),
      .DECIMAL_BITS (DECIMAL_BITS)
   ) u_log (
      .CLK         (CLK),
      .RST         (RST),
      .data        (log_in),
      .output_data (log_out)
   );

   // Pointer advances past the winner after every grant, holds otherwise.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= '0;
      end else if (issue) begin
         rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Tag shift registers run alongside the log core so the tail lines up
   // with output_data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sr_valid <= '0;
         sr_err   <= '0;
         for (int i = 0; i < LAT; i++) sr_id[i] <= '0;
      end else begin
         sr_valid[0] <= issue;
         sr_err[0]   <= issue && sel_err;
         sr_id[0]    <= issue ? grant_idx : '0;
         for (int i = 1; i < LAT; i++) begin
            sr_valid[i] <= sr_valid[i-1];
            sr_err[i]   <= sr_err[i-1];
            sr_id[i]    <= sr_id[i-1];
         end
      end
   end

   assign push       = sr_valid[LAT-1];
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !fifo_empty && bus.rsp_ready;

   // Result FIFO; error results are stored as zero.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         assert (!(push && fifo_count == CW'(FIFO_DEPTH)));
         if (push) begin
            fifo_data[wr_ptr] <= sr_err[LAT-1] ? 32'd0 : log_out;
            fifo_id[wr_ptr]   <= sr_id[LAT-1];
            fifo_err[wr_ptr]  <= sr_err[LAT-1];
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Head of FIFO drives the response; fields read as zero when empty.
   always_comb begin
      bus.rsp_valid = !fifo_empty;
      bus.rsp_data  = fifo_empty ? 32'd0 : fifo_data[rd_ptr];
      bus.rsp_id    = fifo_empty ? '0 : fifo_id[rd_ptr];
      bus.rsp_err   = fifo_empty ? 1'b0 : fifo_err[rd_ptr];
      bus.busy      = (|sr_valid) || !fifo_empty;
   end
endmodule

// File: tb/tb_log_sched.sv
// Bench for log_sched: directed requests with hand-computed ln results,
// a scoreboard queue filled at each accepted request and drained by a
// monitor at every response handshake.
module tb_log_sched;
   localparam int NREQ = 4, IDW = 2, N_STAGE = 2, DECIMAL_BITS = 10;
   localparam int FIFO_DEPTH = 8;
   localparam int W = 32 + IDW + 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   log_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   log_sched #(
      .NREQ(NREQ), .IDW(IDW), .N_STAGE(N_STAGE),
      .DECIMAL_BITS(DECIMAL_BITS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic [W-1:0]    exp_q[$];
   int              grant_q[$];
   int              n_tests = 0;
   int              n_fail  = 0;
   logic [31:0]     drv_exp_data [NREQ];
   logic            drv_exp_err  [NREQ];
   logic [NREQ-1:0] acc_mask = '0;
   int              acc_count = 0;
   int              last_acc_cyc = 0;
   int              rv_seen = 0;
   bit              stream_mode = 0;
   bit              stream_seen = 0;
   int              stream_gaps = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: records accepts into the scoreboard and checks responses.
   always @(negedge CLK) begin
      logic [W-1:0] e;
      acc_mask = '0;
      if (RST) begin
         exp_q.delete();
      end else begin
         check("req_ready_legal",
               64'(((bus.req_ready & ~bus.req_valid) == '0) && ($countones(bus.req_ready) <= 1)), 64'd1);
         acc_mask = bus.req_valid & bus.req_ready;
         for (int k = 0; k < NREQ; k++) begin
            if (acc_mask[k]) begin
               exp_q.push_back({drv_exp_data[k], IDW'(k), drv_exp_err[k]});
               grant_q.push_back(k);
               acc_count++;
               last_acc_cyc = cyc;
            end
         end
         if (bus.rsp_valid) begin
            rv_seen++;
            if (stream_mode) stream_seen = 1;
            if (bus.rsp_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: got id %0d data %0h, expected none", bus.rsp_id, bus.rsp_data);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data_id_err", 64'({bus.rsp_data, bus.rsp_id, bus.rsp_err}), 64'(e));
               end
            end
         end else begin
            check("rsp_idle_zero", 64'({bus.rsp_data, bus.rsp_id, bus.rsp_err}), 64'd0);
            if (stream_mode && stream_seen && exp_q.size() > 0) stream_gaps++;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
      #1;
   endtask

   task automatic set_req(input int k, input logic [31:0] x, input logic [31:0] ed);
      bus.req_data[k*32 +: 32] = x;
      drv_exp_err[k]  = ($signed(x) <= 0);
      drv_exp_data[k] = ed;
   endtask

   task automatic send_one(input int k, input logic [31:0] x, input logic [31:0] ed);
      bit got = 0;
      step();
      set_req(k, x, ed);
      bus.req_valid[k] = 1'b1;
      for (int t = 0; t < 20 && !got; t++) begin
         sample();
         if (acc_mask[k]) got = 1;
      end
      check("send_accepted", 64'(got), 64'd1);
      step();
      bus.req_valid[k] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) sample();
      check("drain_complete", 64'(exp_q.size()), 64'd0);
      repeat (2) sample();
   endtask

   task automatic first_grant(input int k_exp);
      step();
      for (int k = 0; k < NREQ; k++) set_req(k, 32'd1024, 32'd0);
      bus.req_valid = '1;
      sample();
      check("first_grant", 64'(acc_mask), 64'(1 << k_exp));
      step();
      bus.req_valid = '0;
      drain();
   endtask

   function automatic logic [31:0] rand_x();
      logic [31:0] v;
      if ($urandom_range(0, 9) == 0) begin
         v = 32'($urandom_range(0, 100));
         return (~v) + 32'd1;
      end
      return 32'($urandom_range(1, 8192));
   endfunction

   function automatic logic [31:0] golden(input logic [31:0] x);
      longint d, sq;
      if ($signed(x) <= 0) return 32'd0;
      d  = longint'($signed(x)) - 1024;
      sq = d * d;
      return 32'(d - sq / 2048);
   endfunction

   initial begin
      int t_acc, c0, a0, base, rv0;
      bit got;
      logic [31:0] x;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         drv_exp_data[k] = '0;
         drv_exp_err[k]  = 1'b0;
      end

      // Reset values, with requests pending to show ready is held low.
      RST = 1'b1;
      repeat (3) step();
      bus.req_valid = '1;
      sample();
      check("reset_req_ready", 64'(bus.req_ready), 64'd0);
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset_rsp_fields", 64'({bus.rsp_data, bus.rsp_id, bus.rsp_err}), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      step();
      bus.req_valid = '0;
      RST = 1'b0;
      step();

      // Fairness: all requesters valid for 8 cycles.
      set_req(0, 32'd1024, 32'd0);
      set_req(1, 32'd2048, 32'd512);
      set_req(2, 32'd1536, 32'd384);
      set_req(3, 32'd512,  32'hFFFFFD80);
      grant_q.delete();
      bus.req_valid = '1;
      repeat (8) step();
      bus.req_valid = '0;
      check("fair_count", 64'(grant_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < grant_q.size(); i++) check("fair_order", 64'(grant_q[i]), 64'(i % 4));
      drain();

      // Single op from requester 1, latency and busy.
      step();
      set_req(1, 32'd1024, 32'd0);
      bus.req_valid = 4'b0010;
      t_acc = -100;
      for (int t = 0; t < 10; t++) begin
         sample();
         if (acc_mask[1]) begin
            t_acc = cyc;
            break;
         end
      end
      step();
      bus.req_valid = '0;
      got = 0;
      for (int t = 0; t < 20; t++) begin
         sample();
         if (bus.rsp_valid) begin
            got = 1;
            break;
         end
      end
      check("single_latency", 64'(cyc - t_acc), 64'd4);
      check("single_busy_hi", 64'(bus.busy), 64'd1);
      sample();
      check("single_busy_lo", 64'(bus.busy), 64'd0);
      drain();

      // Error path and boundary operands.
      send_one(0, 32'd0,        32'd0);
      send_one(0, 32'd2048,     32'd512);
      send_one(0, 32'hFFFFFFFB, 32'd0);
      send_one(2, 32'h80000000, 32'd0);
      drain();

      // Pointer frozen while idle: last grant was 2, so 3 is next.
      repeat (5) sample();
      first_grant(3);

      // Back-pressure: consumer stalled, credits cap accepts at FIFO_DEPTH.
      step();
      bus.rsp_ready = 1'b0;
      set_req(0, 32'd1280, 32'd224);
      set_req(1, 32'd768,  32'hFFFFFEE0);
      set_req(2, 32'd4096, 32'hFFFFFA00);
      set_req(3, 32'd3072, 32'd0);
      a0 = acc_count;
      bus.req_valid = '1;
      repeat (20) sample();
      check("bp_accepts", 64'(acc_count - a0), 64'd8);
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
      step();
      c0 = cyc;
      bus.rsp_ready = 1'b1;
      for (int t = 0; t < 10 && acc_count == a0 + 8; t++) sample();
      check("bp_resume_cycle", 64'(last_acc_cyc), 64'(c0 + 1));
      step();
      bus.req_valid = '0;
      drain();

      // Reset with three ops in flight.
      step();
      set_req(0, 32'd1024, 32'd0);
      set_req(1, 32'd2048, 32'd512);
      set_req(2, 32'd1536, 32'd384);
      bus.req_valid = 4'b0111;
      for (int t = 0; t < 20 && bus.req_valid != '0; t++) begin
         sample();
         bus.req_valid = bus.req_valid & ~acc_mask;
      end
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      rv0 = rv_seen;
      repeat (10) sample();
      check("rst_no_rsp", 64'(rv_seen - rv0), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      first_grant(0);

      // Steady random stream with the consumer always ready.
      step();
      for (int k = 0; k < NREQ; k++) begin
         x = rand_x();
         set_req(k, x, golden(x));
      end
      base = acc_count;
      stream_mode = 1;
      stream_gaps = 0;
      bus.req_valid = '1;
      for (int c = 0; c < 400; c++) begin
         sample();
         step();
         if (acc_count - base >= 100) begin
            bus.req_valid = '0;
            break;
         end
         for (int k = 0; k < NREQ; k++) begin
            if (acc_mask[k]) begin
               x = rand_x();
               set_req(k, x, golden(x));
            end
         end
      end
      bus.req_valid = '0;
      check("stream_issued", 64'(acc_count - base), 64'd100);
      drain();
      stream_mode = 0;
      check("stream_no_gaps", 64'(stream_gaps), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
